// File: rtl/mult_rev_seq_if.sv
// Request/result bundle for the sequential reversible multiplier.
// The master issues operands and consumes results; the slave is the
// multiplier itself.
interface mult_rev_seq_if #(
  parameter int WIDTH = 8
);
  // Request channel
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_dir;
  logic [WIDTH-1:0]       in_a;
  logic [WIDTH-1:0]       in_b;
  logic [WIDTH-1:0]       in_e;
  logic [2*WIDTH-1:0]     in_p;

  // Result channel
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_dir;
  logic [2*WIDTH-1:0]     out_p;
  logic [WIDTH-1:0]       out_a;
  logic [WIDTH-1:0]       out_b;
  logic [WIDTH-1:0]       out_e;
  logic                   out_err;
  logic                   out_ninv;

  modport master (
    output in_valid, in_dir, in_a, in_b, in_e, in_p, out_ready,
    input  in_ready, out_valid, out_dir, out_p, out_a, out_b, out_e,
           out_err, out_ninv
  );

  modport slave (
    input  in_valid, in_dir, in_a, in_b, in_e, in_p, out_ready,
    output in_ready, out_valid, out_dir, out_p, out_a, out_b, out_e,
           out_err, out_ninv
  );
endinterface

// File: rtl/mult_rev_seq.sv
// Sequential reversible multiplier.
// Forward:  P = A*B + E by W shift-add steps, accumulator seeded with E.
// Backward: B = P / A, E = P % A by W restoring-division steps, MSB first.
// One request in flight; results held until the consumer takes them.
// WIDTH must be at least 2.
module mult_rev_seq #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  mult_rev_seq_if.slave  bus
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic             r_dir;
  logic             r_err;
  logic             r_ninv;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [PW-1:0]    r_acc;   // forward: accumulator; backward: {remainder, quotient/dividend}
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_last;
  logic             w_bwd_err;
  logic [PW-1:0]    w_a_ext;
  logic [PW-1:0]    w_addend;
  logic [PW-1:0]    w_fwd_next;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_next;
  logic [PW-1:0]    w_div_next;

  assign w_accept  = bus.in_valid && (r_state == S_IDLE);
  assign w_last    = (r_cnt == CW'(WIDTH - 1));
  // A quotient fits in W bits only if the upper half of P is below A.
  assign w_bwd_err = (bus.in_a == '0) || (bus.in_p[PW-1:WIDTH] >= bus.in_a);

  // Forward step: add A<<i when B[i] is set.
  assign w_a_ext    = {{WIDTH{1'b0}}, r_a};
  assign w_addend   = r_b[r_cnt] ? (w_a_ext << r_cnt) : '0;
  assign w_fwd_next = r_acc + w_addend;

  // Backward step: shift the next dividend bit into the partial remainder,
  // subtract A if it fits, and shift the quotient bit in at the bottom.
  assign w_trial    = {r_acc[PW-1:WIDTH], r_acc[WIDTH-1]};
  assign w_ge       = (w_trial >= {1'b0, r_a});
  assign w_diff     = w_trial - {1'b0, r_a};
  assign w_rem_next = w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_div_next = {w_rem_next, r_acc[WIDTH-2:0], w_ge};

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and output decode; outputs are zero outside DONE.
  // NOTE: every signal gets a default first so no path leaves one
  // unassigned, which would infer a latch.
  always_comb begin
    w_next        = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_dir   = 1'b0;
    bus.out_p     = '0;
    bus.out_a     = '0;
    bus.out_b     = '0;
    bus.out_e     = '0;
    bus.out_err   = 1'b0;
    bus.out_ninv  = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          w_next = (bus.in_dir && w_bwd_err) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        bus.out_valid = 1'b1;
        bus.out_dir   = r_dir;
        bus.out_a     = r_a;
        bus.out_err   = r_err;
        if (r_dir) begin
          if (!r_err) begin
            bus.out_b = r_acc[WIDTH-1:0];
            bus.out_e = r_acc[PW-1:WIDTH];
          end
        end else begin
          bus.out_p    = r_acc;
          bus.out_ninv = r_ninv;
        end
        if (bus.out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand latch at accept, then one arithmetic step per CALC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dir  <= 1'b0;
      r_err  <= 1'b0;
      r_ninv <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_dir  <= bus.in_dir;
      r_a    <= bus.in_a;
      r_b    <= bus.in_b;
      r_cnt  <= '0;
      r_acc  <= bus.in_dir ? bus.in_p : {{WIDTH{1'b0}}, bus.in_e};
      r_err  <= bus.in_dir && w_bwd_err;
      r_ninv <= !bus.in_dir && (bus.in_e >= bus.in_a);
    end else if (r_state == S_CALC) begin
      r_acc <= r_dir ? w_div_next : w_fwd_next;
      r_cnt <= r_cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_mult_rev_seq.sv
// Scoreboard bench for mult_rev_seq (WIDTH=8): directed vectors push
// hand-computed results; a monitor pops and compares on each handshake.
module tb_mult_rev_seq;
  localparam int W = 8;

  typedef struct packed {
    logic          dir;
    logic [2*W-1:0] p;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  e;
    logic          err;
    logic          ninv;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  mult_rev_seq_if #(.WIDTH(W)) bus ();

  mult_rev_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every consumed result against the oldest expectation.
  always @(negedge clk) begin
    exp_t x;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        x = sb_q.pop_front();
        check("out_dir",  bus.out_dir,  x.dir);
        check("out_p",    bus.out_p,    x.p);
        check("out_a",    bus.out_a,    x.a);
        check("out_b",    bus.out_b,    x.b);
        check("out_e",    bus.out_e,    x.e);
        check("out_err",  bus.out_err,  x.err);
        check("out_ninv", bus.out_ninv, x.ninv);
      end
    end
  end

  task automatic push(input logic dir, input logic [2*W-1:0] p, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] e,
                      input logic err, input logic ninv);
    exp_t x;
    x = '{dir: dir, p: p, a: a, b: b, e: e, err: err, ninv: ninv};
    sb_q.push_back(x);
  endtask

  // Present a request, wait for acceptance; returns #1 after the accepting edge.
  task automatic issue(input logic dir, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] e, input logic [2*W-1:0] p);
    int guard;
    bus.in_valid = 1'b1;
    bus.in_dir   = dir;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_e     = e;
    bus.in_p     = p;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("accept_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Count edges from the accepting edge (edge 1) until out_valid is seen.
  task automatic wait_valid(input int exp_lat);
    int lat;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, exp_lat);
  endtask

  task automatic wait_drop();
    int guard;
    guard = 0;
    while (bus.out_valid && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    check("out_valid_drop", bus.out_valid, 0);
  endtask

  task automatic send(input logic dir, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] e, input logic [2*W-1:0] p,
                      input logic [2*W-1:0] xp, input logic [W-1:0] xb,
                      input logic [W-1:0] xe, input logic xerr, input logic xninv,
                      input int exp_lat);
    push(dir, xp, a, xb, xe, xerr, xninv);
    issue(dir, a, b, e, p);
    wait_valid(exp_lat);
    wait_drop();
  endtask

  initial begin
    int guard;
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_dir    = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_e      = '0;
    bus.in_p      = '0;
    bus.out_ready = 1'b1;
    #12;
    check("rst_in_ready",  bus.in_ready,  1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_p",     bus.out_p,     0);
    check("rst_out_a",     bus.out_a,     0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Forward basic, backward round trip.
    send(1'b0, 8'd13, 8'd200, 8'd7, 16'd0,    16'd2607, 8'd0,   8'd0,   1'b0, 1'b0, 9);
    send(1'b1, 8'd13, 8'd0,   8'd0, 16'd2607, 16'd0,    8'd200, 8'd7,   1'b0, 1'b0, 9);
    // Extremes: 255*255+254 = 0xFEFF, then recovered.
    send(1'b0, 8'd255, 8'd255, 8'd254, 16'd0,      16'hFEFF, 8'd0,   8'd0,   1'b0, 1'b0, 9);
    send(1'b1, 8'd255, 8'd0,   8'd0,   16'hFEFF,   16'd0,    8'd255, 8'd254, 1'b0, 1'b0, 9);
    // Error paths: divide by zero, quotient overflow.
    send(1'b1, 8'd0,   8'd0, 8'd0, 16'd1234,  16'd0, 8'd0, 8'd0, 1'b1, 1'b0, 1);
    send(1'b1, 8'h10,  8'd0, 8'd0, 16'hFFFF,  16'd0, 8'd0, 8'd0, 1'b1, 1'b0, 1);
    // Non-invertible forward: E >= A.
    send(1'b0, 8'd13, 8'd200, 8'd20, 16'd0, 16'd2620, 8'd0, 8'd0, 1'b0, 1'b1, 9);
    send(1'b0, 8'd0,  8'd5,   8'd9,  16'd0, 16'd9,    8'd0, 8'd0, 1'b0, 1'b1, 9);
    // Backward boundary: A=1, largest legal P.
    send(1'b1, 8'd1, 8'd0, 8'd0, 16'h00FF, 16'd0, 8'd255, 8'd0, 1'b0, 1'b0, 9);

    // Backpressure with a competing request held on the input.
    bus.out_ready = 1'b0;
    push(1'b0, 16'd2607, 8'd13, 8'd0, 8'd0, 1'b0, 1'b0);
    issue(1'b0, 8'd13, 8'd200, 8'd7, 16'd0);
    wait_valid(9);
    bus.in_valid = 1'b1;
    bus.in_dir   = 1'b0;
    bus.in_a     = 8'd2;
    bus.in_b     = 8'd3;
    bus.in_e     = 8'd4;
    bus.in_p     = 16'd0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_out_p",     bus.out_p,     2607);
      check("bp_in_ready",  bus.in_ready,  0);
    end
    push(1'b0, 16'd10, 8'd2, 8'd0, 8'd0, 1'b0, 1'b1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_in_ready",  bus.in_ready,  1);
    check("bp_idle_out_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp_second_accepted", bus.in_ready, 0);
    wait_valid(9);
    wait_drop();

    // Reset while in CALC, at step 4.
    issue(1'b0, 8'd100, 8'd100, 8'd0, 16'd0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_in_ready",  bus.in_ready,  1);
    check("midrst_out_p",     bus.out_p,     0);
    check("midrst_out_a",     bus.out_a,     0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    send(1'b0, 8'd10, 8'd10, 8'd3, 16'd0, 16'd103, 8'd0, 8'd0, 1'b0, 1'b0, 9);

    guard = 0;
    while (sb_q.size() != 0 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    check("scoreboard_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
